// File: rtl/nand_sweep_pkg.sv
// Shared types and helpers for the NAND sweep sequencer: state encoding,
// golden NAND model and parameter legality checks.
package nand_sweep_pkg;

  localparam int unsigned MaxWidth = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StCheck  = 2'd2,
    StFinish = 2'd3
  } sweep_state_e;

  // Bits above 'width' are forced high so they cannot affect the reduction.
  function automatic logic nand_exp(input logic [MaxWidth-1:0] vec, input int unsigned width);
    logic [MaxWidth-1:0] mask;
    mask = MaxWidth'((1 << width) - 1);
    return ~&(vec | ~mask);
  endfunction

  function automatic bit width_legal(input int unsigned w);
    return (w >= 1) && (w <= MaxWidth);
  endfunction

  function automatic bit settle_legal(input int unsigned s);
    return s >= 1;
  endfunction

  function automatic bit err_w_legal(input int unsigned e);
    return (e >= 1) && (e <= 32);
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Per-vector settle counter: cleared by load, counts while en, flags the last
// settle cycle of a vector.
module sweep_settle_timer
  import nand_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (!settle_legal(SETTLE)) begin : gen_bad_settle
    $error("sweep_settle_timer: SETTLE must be >= 1");
  end

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CntW'(SETTLE - 1));

endmodule

// File: rtl/nand_sweep_ctrl.sv
// Self-checking sweep sequencer: walks all 2^WIDTH input vectors, settles,
// compares the DUT output against NAND and reports errors and first failure.
module nand_sweep_ctrl
  import nand_sweep_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_y,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_vec
);

  if (!width_legal(WIDTH)) begin : gen_bad_width
    $error("nand_sweep_ctrl: WIDTH must be in 1..8");
  end
  if (!err_w_legal(ERR_W)) begin : gen_bad_err_w
    $error("nand_sweep_ctrl: ERR_W must be in 1..32");
  end

  sweep_state_e     state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic [WIDTH-1:0] fail_vec_q, fail_vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_valid_q, fail_valid_d;
  logic             settle_expired;
  logic             mismatch;
  logic             last_vec;

  // Timer is held at zero outside WAIT so each vector starts a fresh count.
  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q != StWait),
    .en      ((state_q == StWait) && !settle_expired),
    .expired (settle_expired)
  );

  assign last_vec = &vec_q;
  assign mismatch = (dut_y != nand_exp(MaxWidth'(vec_q), WIDTH));

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    stim_d       = stim_q;
    fail_vec_d   = fail_vec_q;
    err_d        = err_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_valid_d = fail_valid_q;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        stim_d = '0;
        if (start && !abort) begin
          state_d      = StWait;
          vec_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
        end
      end
      StWait: begin
        stim_d = vec_q;
        if (settle_expired) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
        end
        if (last_vec) begin
          state_d = StFinish;
          stim_d  = '0;
        end else begin
          vec_d   = vec_q + WIDTH'(1);
          stim_d  = vec_q + WIDTH'(1);
          state_d = StWait;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort drops the sweep before any compare; result registers keep what was seen.
    if (abort && ((state_q == StWait) || (state_q == StCheck))) begin
      state_d      = StIdle;
      vec_d        = '0;
      stim_d       = '0;
      busy_d       = 1'b0;
      pass_d       = 1'b0;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      stim_q       <= '0;
      fail_vec_q   <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      stim_q       <= stim_d;
      fail_vec_q   <= fail_vec_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: doc/nand_sweep_ctrl.md
Name: nand_sweep_ctrl

Overview:
Self-checking sequencer for an N-input NAND datapath (nand2 and wider variants). On a start request it walks the DUT inputs through all 2^WIDTH vectors in ascending order and waits a programmable settle time per vector. It then samples the DUT output, compares it against the golden NAND result, and reports an error count, the first failing vector, and pass/done status. It replaces free-running stimulus blocks in the lab drivers, so benches get a deterministic, cycle-accurate sweep.

Parameters:
- WIDTH, 2, number of DUT inputs; legal range 1..8.
- SETTLE, 2, cycles a vector is held before sampling; legal range >= 1.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running sweep.
- dut_y  in  1  DUT output under test.
- stim  out  WIDTH  vector driven to the DUT inputs.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes normally.
- pass  out  1  high when the last completed sweep had zero errors.
- err_cnt  out  ERR_W  mismatches in the current or last sweep; saturating.
- fail_valid  out  1  high once any mismatch has been recorded.
- fail_vec  out  WIDTH  vector of the first mismatch.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - stim=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, fail_vec=0.
  - Internal vector and settle counters are 0.
  - Reset during a sweep discards it with no done pulse.
- States: IDLE, WAIT, CHECK, FINISH.
- IDLE:
  - busy=0, stim=0.
  - start=1 moves to WAIT. On that edge: vec=0, wcnt=0, err_cnt=0, fail_valid=0, fail_vec=0, pass=0, busy=1.
- WAIT:
  - stim=vec.
  - wcnt increments each cycle.
  - When wcnt==SETTLE-1, move to CHECK.
- CHECK:
  - Compare dut_y with exp = ~&vec.
  - On mismatch: err_cnt+1, saturating at 2^ERR_W-1. If fail_valid=0, capture fail_vec=vec and set fail_valid=1.
  - If vec == all-ones, move to FINISH.
  - Otherwise vec+1, wcnt=0, and move to WAIT.
  - stim stays at vec during CHECK.
- FINISH (one cycle):
  - done=1, pass=(err_cnt==0), busy=0, then move to IDLE.
  - err_cnt, fail_valid, fail_vec and pass hold until the next start.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - done is asserted 2^WIDTH*(SETTLE+1)+1 cycles after the edge that accepted start.
- Simultaneous and boundary events:
  - start while busy=1: ignored.
  - abort in WAIT or CHECK: next state IDLE. stim=0, busy=0, no done pulse, pass=0; err_cnt and fail_* hold.
  - abort and start together in IDLE: abort wins and start is ignored.
  - abort in FINISH: ignored; done still pulses.
  - Vector counter overflow: none; the sweep ends at all-ones.
  - WIDTH=1: vectors 0,1.
- dut_y must not be used combinationally to drive any output; it is sampled only in CHECK.

Decomposition:
- Shared package nand_sweep_pkg holds:
  - the state encoding constants (IDLE=0, WAIT=1, CHECK=2, FINISH=3);
  - the function nand_exp(vec) returning ~&vec;
  - the parameter legality checks.
- One natural sub-module, sweep_settle_timer:
  - inputs: clk, rst_n, load, en;
  - output: expired when count==SETTLE-1.

Test Plan:
- WIDTH=2, SETTLE=2, correct nand2 on dut_y, start pulse:
  - stim sequence 0,1,2,3, each held 3 cycles;
  - done pulses 13 cycles after start; pass=1, err_cnt=0, fail_valid=0.
- Same setup, dut_y stuck at 1:
  - mismatch only at vec=3;
  - err_cnt=1, fail_vec=2'b11, fail_valid=1, pass=0.
- dut_y replaced by AND (inverted NAND):
  - err_cnt=4, fail_vec=0, pass=0.
- abort asserted 5 cycles after start:
  - busy falls on the next edge and stim=0;
  - no done pulse; pass=0.
- Mid-sweep rst_n low for 1 cycle (asynchronous, between edges):
  - all outputs return to 0 immediately;
  - a new start runs a full clean sweep with pass=1.
- WIDTH=8, SETTLE=1, ERR_W=4, dut_y stuck at 0:
  - 1 correct vector (255), 255 mismatches;
  - err_cnt saturates at 15, fail_vec=0;
  - done at 513 cycles.
